win7_frame_ctrl: RTL and testbench

- Frame sequencer in front of the 7-row line-buffer and 7x7 zero-padding window stage.
- Accepts a raster pixel stream for one NxN frame and drives the line-buffer shift enable and pixel.
- Inserts the trailing zero flush pixels so that bottom and right border windows are emitted.
- Tags each push that completes a window centre with its row and column, and signals frame completion.

---
 rtl/win7_frame_ctrl_if.sv | 39 +++
 rtl/win7_frame_ctrl.sv | 142 ++++++++++++++
 tb/tb_win7_frame_ctrl.sv | 234 +++++++++++++++++++++++
 3 files changed

// File: rtl/win7_frame_ctrl_if.sv
// Signal bundle for win7_frame_ctrl; slave = the controller, master = pixel source and consumer.
// Defining WIN7_FRAME_CTRL_PERF_EN adds perf_stall_cnt_o.
interface win7_frame_ctrl_if;
   logic        start_i;
   logic [8:0]  img_size_i;
   logic [7:0]  pix_i;
   logic        pix_valid_i;
   logic        stall_i;
   logic        ready_o;
   logic        shift_en_o;
   logic [7:0]  pix_o;
   logic        win_valid_o;
   logic [8:0]  row_o;
   logic [8:0]  col_o;
   logic        busy_o;
   logic        frame_done_o;
   logic        cfg_err_o;
`ifdef WIN7_FRAME_CTRL_PERF_EN
   logic [15:0] perf_stall_cnt_o;
`endif

   modport slave (
      input  start_i, img_size_i, pix_i, pix_valid_i, stall_i,
      output ready_o, shift_en_o, pix_o, win_valid_o, row_o, col_o,
             busy_o, frame_done_o, cfg_err_o
`ifdef WIN7_FRAME_CTRL_PERF_EN
      , output perf_stall_cnt_o
`endif
   );

   modport master (
      output start_i, img_size_i, pix_i, pix_valid_i, stall_i,
      input  ready_o, shift_en_o, pix_o, win_valid_o, row_o, col_o,
             busy_o, frame_done_o, cfg_err_o
`ifdef WIN7_FRAME_CTRL_PERF_EN
      , input perf_stall_cnt_o
`endif
   );
endinterface

// File: rtl/win7_frame_ctrl.sv
// Frame sequencer for the 7x7 zero-padded window stage: feeds N*N pixels, then 3N+3 zero flush pushes.
// Optional stall counter output enabled by WIN7_FRAME_CTRL_PERF_EN.
module win7_frame_ctrl #(
   parameter int MIN_SIZE = 7,
   parameter int MAX_SIZE = 320
) (
   input  logic             clk,
   input  logic             rst,
   win7_frame_ctrl_if.slave bus
);
   typedef enum logic [2:0] {S_IDLE, S_FILL, S_STREAM, S_FLUSH, S_DONE} state_t;

   state_t      state_q, state_d;
   logic [8:0]  n_q;
   logic [17:0] k_q, l_q, nn_q, last_q;
   logic [8:0]  crow_q, ccol_q;
   logic        shift_en_q, win_valid_q, busy_q, frame_done_q, cfg_err_q;
   logic [7:0]  pix_q;
   logic [8:0]  row_q, col_q;

   logic        size_ok, start_acc, ready, push, flushing, win_push;
   logic [17:0] size_ext, nn_new, l_new;

   assign size_ext = {9'd0, bus.img_size_i};
   assign nn_new   = size_ext * size_ext;
   assign l_new    = (size_ext << 1) + size_ext + 18'd3;
   assign size_ok  = (bus.img_size_i >= 9'(MIN_SIZE)) && (bus.img_size_i <= 9'(MAX_SIZE));

   always_ff @(posedge clk) begin
      if (rst) state_q <= S_IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE:   if (start_acc) state_d = S_FILL;
         S_FILL:   if (push && (k_q == l_q - 18'd1)) state_d = S_STREAM;
         S_STREAM: if (push && (k_q == nn_q - 18'd1)) state_d = S_FLUSH;
         S_FLUSH:  if (push && (k_q == last_q)) state_d = S_DONE;
         S_DONE:   state_d = S_IDLE;
         default:  state_d = S_IDLE;
      endcase
   end

   always_comb begin
      ready     = 1'b0;
      push      = 1'b0;
      flushing  = 1'b0;
      start_acc = 1'b0;
      unique case (state_q)
         S_IDLE: start_acc = bus.start_i & size_ok;
         S_FILL, S_STREAM: begin
            ready = ~bus.stall_i;
            push  = bus.pix_valid_i & ~bus.stall_i;
         end
         S_FLUSH: begin
            flushing = 1'b1;
            push     = ~bus.stall_i;
         end
         default: ;
      endcase
   end

   // A push at or beyond the centre offset completes one window centre.
   assign win_push = push & (k_q >= l_q);

   always_ff @(posedge clk) begin
      if (rst) begin
         n_q          <= '0;
         k_q          <= '0;
         l_q          <= '0;
         nn_q         <= '0;
         last_q       <= '0;
         crow_q       <= '0;
         ccol_q       <= '0;
         shift_en_q   <= 1'b0;
         win_valid_q  <= 1'b0;
         busy_q       <= 1'b0;
         frame_done_q <= 1'b0;
         cfg_err_q    <= 1'b0;
         pix_q        <= '0;
         row_q        <= '0;
         col_q        <= '0;
      end else begin
         shift_en_q   <= push;
         win_valid_q  <= win_push;
         frame_done_q <= flushing & push & (k_q == last_q);
         busy_q       <= (state_d != S_IDLE);
         if (push) begin
            pix_q <= flushing ? 8'd0 : bus.pix_i;
            k_q   <= k_q + 18'd1;
         end
         if (win_push) begin
            row_q <= crow_q;
            col_q <= ccol_q;
            if (ccol_q == n_q - 9'd1) begin
               ccol_q <= '0;
               crow_q <= crow_q + 9'd1;
            end else begin
               ccol_q <= ccol_q + 9'd1;
            end
         end
         if ((state_q == S_IDLE) && bus.start_i) cfg_err_q <= ~size_ok;
         if (start_acc) begin
            n_q    <= bus.img_size_i;
            nn_q   <= nn_new;
            l_q    <= l_new;
            last_q <= nn_new + l_new - 18'd1;
            k_q    <= '0;
            crow_q <= '0;
            ccol_q <= '0;
            row_q  <= '0;
            col_q  <= '0;
         end
      end
   end

   assign bus.ready_o      = ready;
   assign bus.shift_en_o   = shift_en_q;
   assign bus.pix_o        = pix_q;
   assign bus.win_valid_o  = win_valid_q;
   assign bus.row_o        = row_q;
   assign bus.col_o        = col_q;
   assign bus.busy_o       = busy_q;
   assign bus.frame_done_o = frame_done_q;
   assign bus.cfg_err_o    = cfg_err_q;

`ifdef WIN7_FRAME_CTRL_PERF_EN
   logic [15:0] perf_q;

   always_ff @(posedge clk) begin
      if (rst || start_acc) begin
         perf_q <= '0;
      end else if (busy_q && bus.stall_i && (perf_q != 16'hFFFF)) begin
         perf_q <= perf_q + 16'd1;
      end
   end

   assign bus.perf_stall_cnt_o = perf_q;
`endif
endmodule

// File: tb/tb_win7_frame_ctrl.sv
// Directed-vector bench for win7_frame_ctrl; tracks pushes, windows and coordinates per frame.
module tb_win7_frame_ctrl;
   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   win7_frame_ctrl_if bus ();
   win7_frame_ctrl dut (.clk(clk), .rst(rst), .bus(bus));

   int pass_cnt = 0;
   int total_cnt = 0;

   int cur_n, cur_nn, fed_cnt, push_cnt, win_cnt, done_cnt, done_aligned;
   int pix_err, coord_err, stall_shift_err, ready_err, ready_drop, shift_no_valid;
   int first_win_at, first_r, first_c, last_r, last_c, exp_r, exp_c, frame_cyc;
   logic rdy_seen, prev_stall, prev_valid;
   logic [7:0] exp_p;

   task automatic clear_stats(input int n);
      cur_n = n; cur_nn = n * n;
      fed_cnt = 0; push_cnt = 0; win_cnt = 0; done_cnt = 0; done_aligned = 0;
      pix_err = 0; coord_err = 0; stall_shift_err = 0; ready_err = 0;
      ready_drop = 0; shift_no_valid = 0;
      first_win_at = -1; first_r = -1; first_c = -1; last_r = -1; last_c = -1;
      exp_r = 0; exp_c = 0;
   endtask

   // One clock: observe ready_o before the edge, then registered outputs just after it.
   task automatic tick();
      #1;
      rdy_seen = bus.ready_o;
      if (bus.stall_i && rdy_seen) ready_err++;
      if (!bus.stall_i && bus.busy_o && !rdy_seen && fed_cnt < cur_nn) ready_drop++;
      if (bus.pix_valid_i && rdy_seen) fed_cnt++;
      prev_stall = bus.stall_i;
      prev_valid = bus.pix_valid_i;
      @(posedge clk);
      #1;
      if (bus.shift_en_o) begin
         exp_p = (push_cnt < cur_nn) ? 8'(push_cnt * 7 + 1) : 8'd0;
         if (bus.pix_o !== exp_p) pix_err++;
         if (prev_stall) stall_shift_err++;
         if (!prev_valid && push_cnt < cur_nn) shift_no_valid++;
         push_cnt++;
      end
      if (bus.win_valid_o) begin
         if (win_cnt == 0) begin
            first_win_at = push_cnt; first_r = int'(bus.row_o); first_c = int'(bus.col_o);
         end
         if (bus.row_o !== 9'(exp_r) || bus.col_o !== 9'(exp_c)) coord_err++;
         last_r = int'(bus.row_o); last_c = int'(bus.col_o);
         win_cnt++;
         if (exp_c == cur_n - 1) begin exp_c = 0; exp_r++; end
         else exp_c++;
      end
      if (bus.frame_done_o) begin
         done_cnt++;
         if (bus.win_valid_o && win_cnt == cur_nn) done_aligned++;
      end
   endtask

   task automatic start_frame(input int n);
      bus.start_i = 1'b1; bus.img_size_i = 9'(n);
      bus.pix_valid_i = 1'b0; bus.stall_i = 1'b0;
      tick();
      bus.start_i = 1'b0;
   endtask

   // vmode 0: valid every cycle, 1: valid on alternate cycles.
   task automatic run_frame(input int n, input int vmode, input int stall_k, input int stall_len,
                            input int fstall_len, input int chg_at, input int chg_sz, input int max_cyc);
      int st_left = 0;
      bit st_done = 0, fst_done = 0;
      frame_cyc = 0;
      while (done_cnt == 0 && frame_cyc < max_cyc) begin
         if (!st_done && stall_len > 0 && fed_cnt == stall_k) begin st_left = stall_len; st_done = 1; end
         if (!fst_done && fstall_len > 0 && push_cnt == n * n + 5) begin st_left = fstall_len; fst_done = 1; end
         if (chg_at >= 0 && fed_cnt == chg_at) bus.img_size_i = 9'(chg_sz);
         bus.stall_i = (st_left > 0);
         if (st_left > 0) st_left--;
         bus.pix_valid_i = (vmode == 0) ? 1'b1 : ((frame_cyc % 2) == 0);
         bus.pix_i = 8'(fed_cnt * 7 + 1);
         tick();
         frame_cyc++;
      end
      bus.pix_valid_i = 1'b0; bus.stall_i = 1'b0;
      $display("frame N=%0d cycles=%0d pushes=%0d windows=%0d done=%0d", n, frame_cyc, push_cnt, win_cnt, done_cnt);
   endtask

   task automatic test_reset();
      bus.start_i = 1'b0; bus.img_size_i = '0; bus.pix_i = '0;
      bus.pix_valid_i = 1'b0; bus.stall_i = 1'b0;
      clear_stats(7);
      rst = 1'b1; tick(); tick();
      rst = 1'b0; tick();
      total_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL reset_busy: got %b want 0", bus.busy_o); else pass_cnt++;
      total_cnt++; if (bus.ready_o !== 1'b0) $display("FAIL reset_ready: got %b want 0", bus.ready_o); else pass_cnt++;
      total_cnt++;
      if ({bus.shift_en_o, bus.win_valid_o, bus.frame_done_o, bus.cfg_err_o} !== 4'b0)
         $display("FAIL reset_flags: got %b want 0000", {bus.shift_en_o, bus.win_valid_o, bus.frame_done_o, bus.cfg_err_o});
      else pass_cnt++;
      total_cnt++;
      if ({bus.pix_o, bus.row_o, bus.col_o} !== 26'd0)
         $display("FAIL reset_data: got pix=%0d row=%0d col=%0d want 0", bus.pix_o, bus.row_o, bus.col_o);
      else pass_cnt++;
   endtask

   task automatic test_basic();
      clear_stats(7);
      start_frame(7);
      total_cnt++; if (bus.busy_o !== 1'b1) $display("FAIL basic_busy_start: got %b want 1", bus.busy_o); else pass_cnt++;
      run_frame(7, 0, -1, 0, 0, -1, 0, 300);
      total_cnt++; if (frame_cyc != 73) $display("FAIL basic_cycles: got %0d want 73", frame_cyc); else pass_cnt++;
      total_cnt++; if (push_cnt != 73) $display("FAIL basic_pushes: got %0d want 73", push_cnt); else pass_cnt++;
      total_cnt++; if (win_cnt != 49) $display("FAIL basic_windows: got %0d want 49", win_cnt); else pass_cnt++;
      total_cnt++; if (first_win_at != 25) $display("FAIL basic_first_win: got push %0d want 25", first_win_at); else pass_cnt++;
      total_cnt++; if (first_r != 0 || first_c != 0) $display("FAIL basic_first_coord: got (%0d,%0d) want (0,0)", first_r, first_c); else pass_cnt++;
      total_cnt++; if (last_r != 6 || last_c != 6) $display("FAIL basic_last_coord: got (%0d,%0d) want (6,6)", last_r, last_c); else pass_cnt++;
      total_cnt++; if (done_aligned != 1) $display("FAIL basic_done_aligned: got %0d want 1", done_aligned); else pass_cnt++;
      total_cnt++; if (pix_err != 0) $display("FAIL basic_pix: got %0d bad pixels want 0", pix_err); else pass_cnt++;
      total_cnt++; if (coord_err != 0) $display("FAIL basic_coords: got %0d bad coords want 0", coord_err); else pass_cnt++;
      tick();
      total_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL basic_busy_end: got %b want 0", bus.busy_o); else pass_cnt++;
   endtask

   task automatic test_valid_toggle();
      clear_stats(7);
      start_frame(7);
      run_frame(7, 1, -1, 0, 0, -1, 0, 400);
      total_cnt++; if (frame_cyc != 121) $display("FAIL toggle_cycles: got %0d want 121", frame_cyc); else pass_cnt++;
      total_cnt++; if (ready_drop != 0) $display("FAIL toggle_ready: got %0d low cycles want 0", ready_drop); else pass_cnt++;
      total_cnt++; if (shift_no_valid != 0) $display("FAIL toggle_shift_no_valid: got %0d want 0", shift_no_valid); else pass_cnt++;
      total_cnt++; if (win_cnt != 49 || push_cnt != 73) $display("FAIL toggle_counts: got win=%0d push=%0d want 49/73", win_cnt, push_cnt); else pass_cnt++;
      total_cnt++; if (coord_err != 0 || pix_err != 0) $display("FAIL toggle_seq: got coord_err=%0d pix_err=%0d want 0/0", coord_err, pix_err); else pass_cnt++;
      tick();
   endtask

   task automatic test_stall();
      clear_stats(7);
      start_frame(7);
      run_frame(7, 0, 30, 5, 3, -1, 0, 300);
      total_cnt++; if (frame_cyc != 81) $display("FAIL stall_cycles: got %0d want 81", frame_cyc); else pass_cnt++;
      total_cnt++; if (ready_err != 0) $display("FAIL stall_ready: got %0d ready-while-stalled want 0", ready_err); else pass_cnt++;
      total_cnt++; if (stall_shift_err != 0) $display("FAIL stall_shift: got %0d shifts on stall want 0", stall_shift_err); else pass_cnt++;
      total_cnt++; if (win_cnt != 49 || push_cnt != 73) $display("FAIL stall_counts: got win=%0d push=%0d want 49/73", win_cnt, push_cnt); else pass_cnt++;
      total_cnt++; if (coord_err != 0 || done_aligned != 1) $display("FAIL stall_seq: got coord_err=%0d aligned=%0d want 0/1", coord_err, done_aligned); else pass_cnt++;
`ifdef WIN7_FRAME_CTRL_PERF_EN
      total_cnt++; if (bus.perf_stall_cnt_o !== 16'd8) $display("FAIL stall_perf: got %0d want 8", bus.perf_stall_cnt_o); else pass_cnt++;
`endif
      tick();
   endtask

   task automatic test_cfg_err();
      clear_stats(8);
      start_frame(6);
      total_cnt++; if (bus.cfg_err_o !== 1'b1 || bus.busy_o !== 1'b0) $display("FAIL cfg_small: got err=%b busy=%b want 1/0", bus.cfg_err_o, bus.busy_o); else pass_cnt++;
      tick();
      start_frame(321);
      total_cnt++; if (bus.cfg_err_o !== 1'b1 || bus.busy_o !== 1'b0) $display("FAIL cfg_large: got err=%b busy=%b want 1/0", bus.cfg_err_o, bus.busy_o); else pass_cnt++;
      tick();
      total_cnt++; if (bus.cfg_err_o !== 1'b1) $display("FAIL cfg_sticky: got %b want 1", bus.cfg_err_o); else pass_cnt++;
      start_frame(8);
      total_cnt++; if (bus.cfg_err_o !== 1'b0 || bus.busy_o !== 1'b1) $display("FAIL cfg_clear: got err=%b busy=%b want 0/1", bus.cfg_err_o, bus.busy_o); else pass_cnt++;
      run_frame(8, 0, -1, 0, 0, -1, 0, 300);
      total_cnt++; if (win_cnt != 64 || push_cnt != 91) $display("FAIL cfg_n8_counts: got win=%0d push=%0d want 64/91", win_cnt, push_cnt); else pass_cnt++;
      total_cnt++; if (last_r != 7 || last_c != 7 || coord_err != 0) $display("FAIL cfg_n8_coords: got last (%0d,%0d) err=%0d want (7,7) 0", last_r, last_c, coord_err); else pass_cnt++;
      tick();
   endtask

   task automatic test_rst_mid();
      int c = 0;
      clear_stats(9);
      start_frame(9);
      while (fed_cnt < 40 && c < 100) begin
         bus.pix_valid_i = 1'b1; bus.pix_i = 8'(fed_cnt * 7 + 1);
         tick(); c++;
      end
      total_cnt++; if (fed_cnt != 40) $display("FAIL rstmid_reach: got k=%0d want 40", fed_cnt); else pass_cnt++;
      bus.pix_valid_i = 1'b0;
      rst = 1'b1; tick();
      total_cnt++;
      if ({bus.ready_o, bus.shift_en_o, bus.win_valid_o, bus.busy_o, bus.frame_done_o, bus.cfg_err_o} !== 6'b0 ||
          {bus.pix_o, bus.row_o, bus.col_o} !== 26'd0)
         $display("FAIL rstmid_outputs: got ctl=%b pix=%0d row=%0d col=%0d want all 0",
                  {bus.ready_o, bus.shift_en_o, bus.win_valid_o, bus.busy_o, bus.frame_done_o, bus.cfg_err_o},
                  bus.pix_o, bus.row_o, bus.col_o);
      else pass_cnt++;
      rst = 1'b0; tick();
      total_cnt++; if (done_cnt != 0) $display("FAIL rstmid_no_done: got %0d want 0", done_cnt); else pass_cnt++;
      clear_stats(7);
      start_frame(7);
      run_frame(7, 0, -1, 0, 0, -1, 0, 300);
      total_cnt++; if (win_cnt != 49 || push_cnt != 73 || coord_err != 0 || done_aligned != 1)
         $display("FAIL rstmid_clean: got win=%0d push=%0d cerr=%0d aligned=%0d want 49/73/0/1", win_cnt, push_cnt, coord_err, done_aligned);
      else pass_cnt++;
      tick();
   endtask

   task automatic test_held_start();
      clear_stats(7);
      bus.start_i = 1'b1; bus.img_size_i = 9'd7;
      tick();
      run_frame(7, 0, -1, 0, 0, 20, 10, 300);
      total_cnt++; if (win_cnt != 49 || push_cnt != 73 || done_cnt != 1) $display("FAIL held_first: got win=%0d push=%0d done=%0d want 49/73/1", win_cnt, push_cnt, done_cnt); else pass_cnt++;
      tick();
      total_cnt++; if (bus.busy_o !== 1'b0) $display("FAIL held_idle: got busy=%b want 0", bus.busy_o); else pass_cnt++;
      clear_stats(10);
      tick();
      bus.start_i = 1'b0;
      total_cnt++; if (bus.busy_o !== 1'b1) $display("FAIL held_relaunch: got busy=%b want 1", bus.busy_o); else pass_cnt++;
      run_frame(10, 0, -1, 0, 0, -1, 0, 400);
      total_cnt++; if (win_cnt != 100 || push_cnt != 133) $display("FAIL held_n10_counts: got win=%0d push=%0d want 100/133", win_cnt, push_cnt); else pass_cnt++;
      total_cnt++; if (last_r != 9 || last_c != 9 || coord_err != 0) $display("FAIL held_n10_coords: got last (%0d,%0d) err=%0d want (9,9) 0", last_r, last_c, coord_err); else pass_cnt++;
      tick();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_valid_toggle();
      test_stall();
      test_cfg_err();
      test_rst_mid();
      test_held_start();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached, got no finish want finish");
      $fatal(1, "watchdog");
   end
endmodule
